// File: rtl/arb_pkg.sv
// Shared types and helpers for the memory request arbiter and its
// round-robin picker.
//   arb_state_t : arbiter FSM states (IDLE, ISSUE, DONE)
//   mem_op_t    : latched memory operation (read / write)
//   idx_w       : width of a channel index, never below 1 bit
//   wrap_add    : (a + b) mod n for a, b already in [0, n)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Works for non-power-of-two n; a single subtract suffices because
  // both operands are already reduced.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority scan.
//   req   : request vector, one bit per channel
//   ptr   : channel with highest priority this cycle
//   valid : at least one request is set
//   idx   : first requesting channel at or after ptr, wrapping at N
module rr_picker
  import arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Rotate so that bit 0 of rot is channel ptr; the doubled vector makes
  // the rotation a plain right shift.
  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  int             k_sel;

  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);

  always_comb begin
    valid = 1'b0;
    k_sel = 0;
    // Descending scan: the lowest offset that requests is written last.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        k_sel = k;
      end
    end
    idx = IW'(wrap_add(int'(ptr), k_sel, N));
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter of NCH requester channels onto one memory port.
// A granted request is held until mem_hit (or timeout), then the owner
// sees a one-cycle req_done pulse with req_err and req_rdata.
//   CLK, RST               : clock, async active-high reset
//   req_ren/req_wen        : per-channel read / write request levels
//   req_addr/req_wdata     : per-channel address / write data, packed
//   req_done/req_err       : one-hot completion / error pulse
//   req_rdata              : read data, valid with req_done
//   mem_ren/mem_wen        : memory strobes, high through ISSUE
//   mem_addr/mem_wdata     : memory address / write data
//   mem_rdata/mem_hit      : memory read data / completion
//   busy                   : high in ISSUE or DONE
//   grant_id               : currently granted channel
module mem_request_arbiter
  import arb_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int AW      = 32,
  parameter  int DW      = 32,
  parameter  int TIMEOUT = 0,
  localparam int IW      = idx_w(NCH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    req_ren,
  input  logic [NCH-1:0]    req_wen,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_done,
  output logic [NCH-1:0]    req_err,
  output logic [DW-1:0]     req_rdata,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_hit,
  output logic              busy,
  output logic [IW-1:0]     grant_id
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    state_q, state_d;
  mem_op_t       op_q, op_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  logic          sel_ren, sel_wen;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          expired;

  rr_picker #(.N(NCH)) u_pick (
    .req   (req_ren | req_wen),
    .ptr   (rr_ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Mux the picked channel's request fields.
  always_comb begin
    sel_ren   = 1'b0;
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_ren   = req_ren[i];
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Expiry is judged on the cycle whose miss would bring the count to
  // TIMEOUT, so the strobe stays up for exactly TIMEOUT cycles.
  assign expired = (TIMEOUT > 0) && ((int'(tcnt_q) + 1) >= TIMEOUT);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          op_d    = sel_wen ? OP_WR : OP_RD;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          tcnt_d  = '0;
          // Read and write together is illegal: complete with error and
          // never touch memory.
          if (sel_ren && sel_wen) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // A hit coinciding with expiry counts as success.
        if (mem_hit) begin
          if (op_q == OP_RD) rdata_d = mem_rdata;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (tcnt_q != {TW{1'b1}}) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE: begin
        rr_ptr_d = IW'(wrap_add(int'(grant_q), 1, NCH));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  always_comb begin
    req_done = '0;
    req_err  = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((state_q == DONE) && (grant_q == IW'(i))) begin
        req_done[i] = 1'b1;
        req_err[i]  = err_q;
      end
    end
  end

  // Everything below decodes registered state, so strobes are glitch-free
  // and drop the instant RST rises.
  assign req_rdata = rdata_q;
  assign mem_ren   = (state_q == ISSUE) && (op_q == OP_RD);
  assign mem_wen   = (state_q == ISSUE) && (op_q == OP_WR);
  assign mem_addr  = (state_q == ISSUE) ? addr_q  : '0;
  assign mem_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign busy      = (state_q == ISSUE) || (state_q == DONE);
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter (NCH=3, TIMEOUT=4). A
// transaction-level model advances on every negedge and the outputs are
// compared against it; directed scenarios add literal expectations.
module tb_mem_request_arbiter;

  localparam int NCH = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 4;
  localparam int IW  = 2;
  localparam logic [DW-1:0] NOISE = 32'h0BAD_0BAD;

  logic              CLK, RST;
  logic [NCH-1:0]    req_ren, req_wen, req_done, req_err;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [DW-1:0]     req_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_ren, mem_wen, mem_hit, busy;
  logic [IW-1:0]     grant_id;

  int n_vec = 0;
  int n_err = 0;

  mem_request_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .req_ren(req_ren), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_hit(mem_hit), .busy(busy), .grant_id(grant_id)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: one owner, a phase, and a wait count ----------
  bit            m_iss, m_done, m_err, m_rd, m_ill;
  int            m_own, m_ptr, m_wait;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [NCH-1:0]    e_vec, rq;
  logic [NCH*AW-1:0] sh_a;
  logic [NCH*DW-1:0] sh_d;
  bit            found;

  initial forever begin
    @(negedge CLK);
    if (RST) begin
      m_iss = 0; m_done = 0; m_err = 0; m_ill = 0; m_rd = 0;
      m_own = 0; m_ptr = 0; m_wait = 0; m_rdata = '0;
    end
    // outputs of the current cycle
    e_vec = m_done ? (NCH'(1) << m_own) : '0;
    chk("req_done", req_done, e_vec);
    chk("req_err", req_err, m_err ? e_vec : '0);
    chk("mem_ren", mem_ren, m_iss && m_rd);
    chk("mem_wen", mem_wen, m_iss && !m_rd);
    chk("busy", busy, m_iss || m_done);
    if (m_iss) begin
      chk("mem_addr", mem_addr, m_addr);
      if (!m_rd) chk("mem_wdata", mem_wdata, m_wdata);
    end
    if (m_iss || m_done) chk("grant_id", grant_id, m_own);
    if (m_done && !m_ill) chk("req_rdata", req_rdata, m_rdata);
    if (RST) begin
      chk("rst_rdata", req_rdata, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_addr", mem_addr, 0);
    end
    // advance with the inputs the next edge will sample
    if (!RST) begin
      if (m_done) begin
        m_done = 0;
        m_ptr  = (m_own + 1) % NCH;
      end else if (m_iss) begin
        if (mem_hit) begin
          m_iss = 0; m_done = 1; m_err = 0; m_ill = 0;
          if (m_rd) m_rdata = mem_rdata;
        end else begin
          m_wait++;
          if (TO > 0 && m_wait == TO) begin
            m_iss = 0; m_done = 1; m_err = 1; m_ill = 0; m_rdata = '0;
          end
        end
      end else begin
        found = 0;
        for (int k = 0; k < NCH; k++) begin
          rq = (req_ren | req_wen) >> ((m_ptr + k) % NCH);
          if (!found && rq[0]) begin
            found = 1;
            m_own = (m_ptr + k) % NCH;
          end
        end
        if (found) begin
          rq = (req_ren & req_wen) >> m_own;
          if (rq[0]) begin
            m_done = 1; m_err = 1; m_ill = 1;
          end else begin
            rq      = req_ren >> m_own;
            m_rd    = rq[0];
            sh_a    = req_addr >> (m_own * AW);
            sh_d    = req_wdata >> (m_own * DW);
            m_addr  = sh_a[AW-1:0];
            m_wdata = sh_d[DW-1:0];
            m_iss   = 1; m_wait = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Serves the memory side until the next req_done. lat = strobe cycle in
  // which mem_hit is raised (0 = never). Optionally drops the finished
  // channel's request in the done cycle.
  task automatic run(input int lat, input logic [DW-1:0] d, input bit drop,
                     output int cyc, output int nstb,
                     output logic [NCH-1:0] dn, output logic [NCH-1:0] er,
                     output logic [DW-1:0] rd, output logic [AW-1:0] a0,
                     output logic [DW-1:0] w0);
    bit fin = 0;
    cyc = 0; nstb = 0; dn = '0; er = '0; rd = '0; a0 = '0; w0 = '0;
    for (int i = 0; i < 40 && !fin; i++) begin
      tick();
      cyc++;
      if (req_done != '0) begin
        fin = 1;
        dn = req_done; er = req_err; rd = req_rdata;
        mem_hit = 0; mem_rdata = NOISE;
        if (drop) begin
          req_ren = req_ren & ~req_done;
          req_wen = req_wen & ~req_done;
        end
      end else if (mem_ren || mem_wen) begin
        nstb++;
        if (nstb == 1) begin a0 = mem_addr; w0 = mem_wdata; end
        if (nstb == lat) begin mem_hit = 1; mem_rdata = d; end
        else begin mem_hit = 0; mem_rdata = NOISE; end
      end else begin
        mem_hit = 0; mem_rdata = NOISE;
      end
    end
    if (!fin) chk("done_within_bound", fin, 1);
  endtask

  int               cyc, nstb;
  logic [NCH-1:0]   dn, er;
  logic [DW-1:0]    rd, w0;
  logic [AW-1:0]    a0;
  logic [NCH-1:0]   exp_g [3];
  logic [AW-1:0]    exp_a [3];
  bit               seen;

  initial begin
    RST = 1; req_ren = '0; req_wen = '0; req_addr = '0; req_wdata = '0;
    mem_hit = 0; mem_rdata = NOISE;
    req_addr[0*AW +: AW] = 32'h40;  req_addr[1*AW +: AW] = 32'h200;
    req_addr[2*AW +: AW] = 32'h300;
    req_wdata[0*DW +: DW] = 32'hA0A0_0000; req_wdata[1*DW +: DW] = 32'hB1B1_0001;
    req_wdata[2*DW +: DW] = 32'hC2C2_0002;
    repeat (3) tick();
    chk("rst_busy_lit", busy, 0);
    chk("rst_strobes_lit", {mem_ren, mem_wen}, 0);
    RST = 0;
    tick();

    // single read, hit in 2nd strobe cycle
    req_ren = 3'b001;
    run(2, 32'hDEADBEEF, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("rd_latency", cyc, 3);
    chk("rd_strobe_cycles", nstb, 2);
    chk("rd_done", dn, 3'b001);
    chk("rd_err", er, 3'b000);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_addr", a0, 32'h40);
    tick();

    // illegal ren&wen on ch1: no strobe, done+err immediately
    req_ren = 3'b010; req_wen = 3'b010;
    run(1, NOISE, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("ill_latency", cyc, 1);
    chk("ill_strobes", nstb, 0);
    chk("ill_done", dn, 3'b010);
    chk("ill_err", er, 3'b010);
    tick();

    // following request proceeds normally
    req_ren = 3'b100;
    run(1, 32'h1234_5678, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("post_ill_done", dn, 3'b100);
    chk("post_ill_err", er, 3'b000);
    chk("post_ill_data", rd, 32'h1234_5678);
    tick();

    // ch0 and ch1 write continuously (rr_ptr now 0): order 0,1,0
    req_addr[0*AW +: AW] = 32'h100;
    req_wen = 3'b011;
    exp_g = '{3'b001, 3'b010, 3'b001};
    exp_a = '{32'h100, 32'h200, 32'h100};
    for (int j = 0; j < 3; j++) begin
      run(1, NOISE, 0, cyc, nstb, dn, er, rd, a0, w0);
      chk("wr_grant", dn, exp_g[j]);
      chk("wr_err", er, 3'b000);
      chk("wr_addr", a0, exp_a[j]);
      chk("wr_data", w0, (j == 1) ? 32'hB1B1_0001 : 32'hA0A0_0000);
      chk("wr_keeps_rdata", rd, 32'h1234_5678);
    end
    req_wen = '0;
    tick();

    // ch1 and ch2 read continuously (rr_ptr now 1): order 1,2,1
    req_ren = 3'b110;
    exp_g = '{3'b010, 3'b100, 3'b010};
    for (int j = 0; j < 3; j++) begin
      run(1, 32'h5000 + j, 0, cyc, nstb, dn, er, rd, a0, w0);
      chk("rr3_grant", dn, exp_g[j]);
      chk("rr3_data", rd, 32'h5000 + j);
    end
    req_ren = '0;
    tick();

    // timeout: ch2 read, no hit
    req_ren = 3'b100;
    run(0, NOISE, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("to_strobe_cycles", nstb, 4);
    chk("to_done", dn, 3'b100);
    chk("to_err", er, 3'b100);
    chk("to_rdata", rd, 32'h0);
    tick();

    // hit on the expiry cycle wins
    req_addr[0*AW +: AW] = 32'h40;
    req_ren = 3'b001;
    run(4, 32'hCAFE_F00D, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("to_hit_strobes", nstb, 4);
    chk("to_hit_done", dn, 3'b001);
    chk("to_hit_err", er, 3'b000);
    chk("to_hit_data", rd, 32'hCAFE_F00D);
    tick();

    // reset mid-ISSUE (rr_ptr now 1, ch1 write in flight)
    req_wen = 3'b010;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (mem_wen) seen = 1;
    end
    chk("rst_issue_reached", seen, 1);
    tick();
    #1 RST = 1;
    #1;
    chk("rst_async_wen", mem_wen, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_done", req_done, 0);
    req_wen = '0;
    tick();
    tick();
    RST = 0;
    tick();
    // ch0 and ch2 request: pointer back at 0 so ch0 wins
    req_ren = 3'b101;
    run(1, 32'h55AA_55AA, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("post_rst_grant", dn, 3'b001);
    chk("post_rst_data", rd, 32'h55AA_55AA);
    run(1, 32'h66BB_66BB, 1, cyc, nstb, dn, er, rd, a0, w0);
    chk("post_rst_next", dn, 3'b100);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
